ant_motion_ctrl: RTL and testbench



---
 rtl/ant_pkg.sv | 33 +++
 rtl/ant_corner_gen.sv | 21 ++
 rtl/ant_motion_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ant_motion_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ant_pkg.sv
// ant_pkg: maze geometry, direction and FSM encodings shared by the ant movement logic.
// Revision 1.0
`default_nettype none

package ant_pkg;

  localparam int TILE     = 60;
  localparam int MAP_COLS = 14;
  localparam int MAP_ROWS = 8;
  localparam int MAP_W    = TILE * MAP_COLS;
  localparam int MAP_H    = TILE * MAP_ROWS;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_PROBE0 = 3'd2,
    S_PROBE1 = 3'd3,
    S_PROBE2 = 3'd4,
    S_PROBE3 = 3'd5,
    S_COMMIT = 3'd6,
    S_REJECT = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ant_corner_gen.sv
// ant_corner_gen: maps a candidate top-left position and corner index to that sprite corner.
// Revision 1.0
`default_nettype none

module ant_corner_gen #(
  parameter int SPRITE = 20
) (
  input  logic [10:0] cx_i,
  input  logic [10:0] cy_i,
  input  logic [1:0]  idx_i,
  output logic [10:0] corner_x_o,
  output logic [10:0] corner_y_o
);

  // Index bit 0 selects the right edge, bit 1 the bottom edge.
  assign corner_x_o = idx_i[0] ? (cx_i + 11'(SPRITE - 1)) : cx_i;
  assign corner_y_o = idx_i[1] ? (cy_i + 11'(SPRITE - 1)) : cy_i;

endmodule

`default_nettype wire

// File: rtl/ant_motion_ctrl.sv
// ant_motion_ctrl: tick-driven ant movement with four-corner walkability probing via the map lookup.
// Revision 1.0
`default_nettype none

module ant_motion_ctrl
  import ant_pkg::*;
#(
  parameter int STEP    = 2,
  parameter int SPRITE  = 20,
  parameter int START_X = 70,
  parameter int START_Y = 70
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        move_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        in_bounds,
  output logic [10:0] probe_x,
  output logic [10:0] probe_y,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        busy,
  output logic        moved,
  output logic        blocked
);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [10:0] probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [10:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;

  logic [11:0] cand_x_w, cand_y_w;
  logic        underflow_w, oob_w;
  logic [10:0] cg_x_w, cg_y_w, corner_x_w, corner_y_w;
  logic [1:0]  cg_idx_w;

  // Candidate is formed in 12 bits so the edge checks cannot wrap.
  always_comb begin
    cand_x_w    = {1'b0, pos_x_q};
    cand_y_w    = {1'b0, pos_y_q};
    underflow_w = 1'b0;
    case (dir_q)
      DIR_UP: begin
        underflow_w = pos_y_q < 11'(STEP);
        cand_y_w    = {1'b0, pos_y_q} - 12'(STEP);
      end
      DIR_DOWN:  cand_y_w = {1'b0, pos_y_q} + 12'(STEP);
      DIR_LEFT: begin
        underflow_w = pos_x_q < 11'(STEP);
        cand_x_w    = {1'b0, pos_x_q} - 12'(STEP);
      end
      DIR_RIGHT: cand_x_w = {1'b0, pos_x_q} + 12'(STEP);
      default: ;
    endcase
  end

  assign oob_w = underflow_w
               | ((cand_x_w + 12'(SPRITE)) > 12'(MAP_W))
               | ((cand_y_w + 12'(SPRITE)) > 12'(MAP_H));

  // CALC feeds the fresh candidate for corner 0; PROBEk asks for corner k+1.
  always_comb begin
    cg_x_w   = cand_x_q;
    cg_y_w   = cand_y_q;
    cg_idx_w = 2'd0;
    case (state_q)
      S_CALC: begin
        cg_x_w = cand_x_w[10:0];
        cg_y_w = cand_y_w[10:0];
      end
      S_PROBE0: cg_idx_w = 2'd1;
      S_PROBE1: cg_idx_w = 2'd2;
      S_PROBE2: cg_idx_w = 2'd3;
      default:  cg_idx_w = 2'd0;
    endcase
  end

  ant_corner_gen #(
    .SPRITE (SPRITE)
  ) u_corner_gen (
    .cx_i       (cg_x_w),
    .cy_i       (cg_y_w),
    .idx_i      (cg_idx_w),
    .corner_x_o (corner_x_w),
    .corner_y_o (corner_y_w)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    case (state_q)
      S_IDLE: begin
        probe_x_d = pos_x_q;
        probe_y_d = pos_y_q;
        if (move_tick && (btn_up || btn_down || btn_left || btn_right)) begin
          if (btn_up)        dir_d = DIR_UP;
          else if (btn_down) dir_d = DIR_DOWN;
          else if (btn_left) dir_d = DIR_LEFT;
          else               dir_d = DIR_RIGHT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (oob_w) begin
          state_d = S_REJECT;
        end else begin
          cand_x_d  = cand_x_w[10:0];
          cand_y_d  = cand_y_w[10:0];
          probe_x_d = corner_x_w;
          probe_y_d = corner_y_w;
          state_d   = S_PROBE0;
        end
      end
      S_PROBE0, S_PROBE1, S_PROBE2: begin
        if (!in_bounds) begin
          state_d = S_REJECT;
        end else begin
          probe_x_d = corner_x_w;
          probe_y_d = corner_y_w;
          case (state_q)
            S_PROBE0: state_d = S_PROBE1;
            S_PROBE1: state_d = S_PROBE2;
            default:  state_d = S_PROBE3;
          endcase
        end
      end
      S_PROBE3: state_d = in_bounds ? S_COMMIT : S_REJECT;
      S_COMMIT: begin
        pos_x_d = cand_x_q;
        pos_y_d = cand_y_q;
        state_d = S_IDLE;
      end
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      pos_x_q   <= 11'(START_X);
      pos_y_q   <= 11'(START_Y);
      probe_x_q <= 11'(START_X);
      probe_y_q <= 11'(START_Y);
      cand_x_q  <= 11'(START_X);
      cand_y_q  <= 11'(START_Y);
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
    end
  end

  assign probe_x = probe_x_q;
  assign probe_y = probe_y_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign busy    = (state_q != S_IDLE);
  assign moved   = (state_q == S_COMMIT);
  assign blocked = (state_q == S_REJECT);

endmodule

`default_nettype wire

// File: tb/tb_ant_motion_ctrl.sv
// tb_ant_motion_ctrl: directed scenarios for ant_motion_ctrl with a simple x-limit walkability model.
// Revision 1.0
`default_nettype none

module tb_ant_motion_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        move_tick = 1'b0, tick2 = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        in_bounds;
  logic [10:0] probe_x, probe_y, pos_x, pos_y;
  logic        busy, moved, blocked;
  logic [10:0] probe_x2, probe_y2, pos_x2, pos_y2;
  logic        busy2, moved2, blocked2;
  logic [11:0] lim_x = 12'd4095;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Walkable wherever x is below lim_x.
  assign in_bounds = ({1'b0, probe_x} < lim_x);

  ant_motion_ctrl dut (
    .clk(clk), .resetn(resetn), .move_tick(move_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_bounds(in_bounds), .probe_x(probe_x), .probe_y(probe_y),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .moved(moved), .blocked(blocked)
  );

  ant_motion_ctrl #(.START_X(0)) dut0 (
    .clk(clk), .resetn(resetn), .move_tick(tick2),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .in_bounds(1'b1), .probe_x(probe_x2), .probe_y(probe_y2),
    .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .moved(moved2), .blocked(blocked2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    move_tick = 1'b1;
    @(posedge clk);
    #1;
    move_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    checks++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    else passes++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    checks++;
    if ({pos_x, pos_y} !== {11'd70, 11'd70}) $display("FAIL reset_pos: got (%0d,%0d) required (70,70)", pos_x, pos_y);
    else passes++;
    checks++;
    if ({probe_x, probe_y} !== {11'd70, 11'd70}) $display("FAIL reset_probe: got (%0d,%0d) required (70,70)", probe_x, probe_y);
    else passes++;
    checks++;
    if ({busy, moved, blocked} !== 3'b000) $display("FAIL reset_flags: busy/moved/blocked=%b required 000", {busy, moved, blocked});
    else passes++;
    checks++;
    if ({pos_x2, pos_y2} !== {11'd0, 11'd70}) $display("FAIL reset_pos_dut0: got (%0d,%0d) required (0,70)", pos_x2, pos_y2);
    else passes++;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_accept_right();
    logic [10:0] ex[4];
    logic [10:0] ey[4];
    ex = '{11'd72, 11'd91, 11'd72, 11'd91};
    ey = '{11'd70, 11'd70, 11'd89, 11'd89};
    tick(0, 0, 0, 1);
    checks++;
    if (busy !== 1'b1) $display("FAIL accept_busy_E0: busy=%b required 1", busy);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({probe_x, probe_y} !== {ex[k], ey[k]})
        $display("FAIL accept_probe%0d: got (%0d,%0d) required (%0d,%0d)", k, probe_x, probe_y, ex[k], ey[k]);
      else passes++;
    end
    step();
    checks++;
    if ({moved, pos_x, pos_y} !== {1'b1, 11'd70, 11'd70})
      $display("FAIL accept_commit_E5: moved=%b pos=(%0d,%0d) required moved=1 pos=(70,70)", moved, pos_x, pos_y);
    else passes++;
    step();
    checks++;
    if ({moved, busy, pos_x, pos_y} !== {1'b0, 1'b0, 11'd72, 11'd70})
      $display("FAIL accept_pos_E6: moved=%b busy=%b pos=(%0d,%0d) required 0 0 (72,70)", moved, busy, pos_x, pos_y);
    else passes++;
    btn_right = 1'b0;
  endtask

  task automatic test_blocked_corner();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1);
      wait_idle();
    end
    checks++;
    if ({pos_x, pos_y} !== {11'd80, 11'd70}) $display("FAIL blocked_setup_pos: got (%0d,%0d) required (80,70)", pos_x, pos_y);
    else passes++;
    lim_x = 12'd100;
    tick(0, 0, 0, 1);
    step();
    checks++;
    if ({probe_x, probe_y, in_bounds} !== {11'd82, 11'd70, 1'b1})
      $display("FAIL blocked_probe0: got (%0d,%0d) ib=%b required (82,70) ib=1", probe_x, probe_y, in_bounds);
    else passes++;
    step();
    checks++;
    if ({probe_x, probe_y, in_bounds} !== {11'd101, 11'd70, 1'b0})
      $display("FAIL blocked_probe1: got (%0d,%0d) ib=%b required (101,70) ib=0", probe_x, probe_y, in_bounds);
    else passes++;
    step();
    checks++;
    if ({blocked, moved, probe_x, probe_y} !== {1'b1, 1'b0, 11'd101, 11'd70})
      $display("FAIL blocked_reject: blocked=%b moved=%b probe=(%0d,%0d) required 1 0 (101,70)", blocked, moved, probe_x, probe_y);
    else passes++;
    step();
    checks++;
    if ({blocked, busy, pos_x, pos_y} !== {1'b0, 1'b0, 11'd80, 11'd70})
      $display("FAIL blocked_after: blocked=%b busy=%b pos=(%0d,%0d) required 0 0 (80,70)", blocked, busy, pos_x, pos_y);
    else passes++;
    lim_x = 12'd4095;
    btn_right = 1'b0;
  endtask

  task automatic test_up_priority_busy();
    int nmoved;
    nmoved = 0;
    tick(1, 0, 0, 1);
    step();
    checks++;
    if ({probe_x, probe_y} !== {11'd80, 11'd68}) $display("FAIL up_probe0: got (%0d,%0d) required (80,68)", probe_x, probe_y);
    else passes++;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      if (moved) nmoved++;
      step();
    end
    btn_right = 1'b0; btn_up = 1'b0;
    checks++;
    if ({pos_x, pos_y} !== {11'd80, 11'd68}) $display("FAIL up_pos: got (%0d,%0d) required (80,68)", pos_x, pos_y);
    else passes++;
    checks++;
    if (nmoved !== 1) $display("FAIL up_single_move: moved pulses=%0d required 1", nmoved);
    else passes++;
  endtask

  task automatic test_left_underflow();
    @(negedge clk);
    btn_left = 1'b1; tick2 = 1'b1;
    @(posedge clk);
    #1;
    tick2 = 1'b0;
    step();
    checks++;
    if ({blocked2, busy2, probe_x2, probe_y2} !== {1'b1, 1'b1, 11'd0, 11'd70})
      $display("FAIL underflow_reject: blocked=%b busy=%b probe=(%0d,%0d) required 1 1 (0,70)", blocked2, busy2, probe_x2, probe_y2);
    else passes++;
    step();
    checks++;
    if ({blocked2, busy2, pos_x2, pos_y2} !== {1'b0, 1'b0, 11'd0, 11'd70})
      $display("FAIL underflow_after: blocked=%b busy=%b pos=(%0d,%0d) required 0 0 (0,70)", blocked2, busy2, pos_x2, pos_y2);
    else passes++;
    btn_left = 1'b0;
  endtask

  task automatic test_reset_mid_probe();
    tick(0, 0, 0, 1);
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({pos_x, pos_y, busy} !== {11'd70, 11'd70, 1'b0})
      $display("FAIL async_reset: pos=(%0d,%0d) busy=%b required (70,70) 0", pos_x, pos_y, busy);
    else passes++;
    checks++;
    if ({probe_x, probe_y} !== {11'd70, 11'd70}) $display("FAIL async_reset_probe: got (%0d,%0d) required (70,70)", probe_x, probe_y);
    else passes++;
    @(negedge clk);
    resetn = 1'b1;
    step();
    tick(0, 0, 0, 1);
    step();
    checks++;
    if ({probe_x, probe_y} !== {11'd72, 11'd70}) $display("FAIL fresh_probe0: got (%0d,%0d) required (72,70)", probe_x, probe_y);
    else passes++;
    repeat (5) step();
    checks++;
    if ({pos_x, pos_y, busy} !== {11'd72, 11'd70, 1'b0})
      $display("FAIL fresh_commit: pos=(%0d,%0d) busy=%b required (72,70) 0", pos_x, pos_y, busy);
    else passes++;
    btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accept_right();
    test_blocked_corner();
    test_up_priority_busy();
    test_left_underflow();
    test_reset_mid_probe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
